// File: rtl/trng_entropy_arbiter.sv
// trng_entropy_arbiter: round-robin scheduler sharing one entropy-mixer input among three sources
// Ports: i_clk/i_reset (async, active-high); i_enable stops new grants; i_discard flushes the output
// stage and forces re-arbitration; i_src_enabled/i_src_valid/i_src_data/o_src_ack form the three
// source handshakes (source i on data bits [32*i+31:32*i]); o_mix_data/o_mix_valid/i_mix_ack feed
// the mixer; o_grant is the granted source (3 = none); o_no_source flags enable with no source
// enabled; o_word_count counts words accepted by the mixer.
module trng_entropy_arbiter #(
  parameter int BURST = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_enable,
  input  logic        i_discard,
  input  logic [2:0]  i_src_enabled,
  input  logic [2:0]  i_src_valid,
  input  logic [95:0] i_src_data,
  output logic [2:0]  o_src_ack,
  output logic [31:0] o_mix_data,
  output logic        o_mix_valid,
  input  logic        i_mix_ack,
  output logic [1:0]  o_grant,
  output logic        o_no_source,
  output logic [31:0] o_word_count
);
  typedef enum logic [1:0] {IDLE, ARB, FETCH, HOLD} state_t;
  state_t      r_state, w_state_n;
  logic [1:0]  r_last, w_last_n, r_grant, w_grant_n, w_c1, w_c2, w_pick;
  logic [7:0]  r_burst, w_burst_n, w_burst_inc;
  logic [2:0]  r_ack, w_ack_n, w_gmask;
  logic [31:0] r_mix_data, w_mix_data_n, r_wc, w_wc_n, w_sel_data;
  logic        r_mix_valid, w_mix_valid_n, r_no_source, w_sel_en, w_sel_valid;
  // Round-robin candidates after last; falling back to last itself covers the third slot.
  assign w_c1 = (r_last == 2'd2) ? 2'd0 : r_last + 2'd1;
  assign w_c2 = (w_c1 == 2'd2) ? 2'd0 : w_c1 + 2'd1;
  assign w_pick = (|(i_src_enabled & (3'b001 << w_c1))) ? w_c1 :
                  (|(i_src_enabled & (3'b001 << w_c2))) ? w_c2 : r_last;
  // One-hot of the granted source; all-zero when grant is 3 so nothing is selected.
  assign w_gmask = 3'b001 << r_grant;
  assign w_sel_en = |(i_src_enabled & w_gmask);
  assign w_sel_valid = |(i_src_valid & w_gmask);
  assign w_sel_data = (r_grant == 2'd0) ? i_src_data[31:0] :
                      (r_grant == 2'd1) ? i_src_data[63:32] : i_src_data[95:64];
  assign w_burst_inc = r_burst + 8'd1;
  always_comb begin
    w_state_n = r_state;
    w_last_n = r_last;
    w_grant_n = r_grant;
    w_burst_n = r_burst;
    w_ack_n = 3'b000;
    w_mix_valid_n = r_mix_valid;
    w_mix_data_n = r_mix_data;
    w_wc_n = r_wc;
    if (i_discard) begin
      w_state_n = i_enable ? ARB : IDLE;
      w_grant_n = 2'd3;
      w_burst_n = 8'd0;
      w_mix_valid_n = 1'b0;
      w_mix_data_n = 32'd0;
    end else begin
      case (r_state)
        IDLE: w_state_n = i_enable ? ARB : IDLE;
        ARB: begin
          w_grant_n = 2'd3;
          if (!i_enable) w_state_n = IDLE;
          else if (|i_src_enabled) begin
            w_grant_n = w_pick;
            w_last_n = w_pick;
            w_burst_n = 8'd0;
            w_state_n = FETCH;
          end
        end
        FETCH: begin
          if (!i_enable || !w_sel_en) begin
            w_state_n = i_enable ? ARB : IDLE;
            w_grant_n = 2'd3;
          end else if (w_sel_valid) begin
            w_mix_data_n = w_sel_data;
            w_ack_n = w_gmask;
            w_mix_valid_n = 1'b1;
            w_state_n = HOLD;
          end
        end
        HOLD: begin
          if (i_mix_ack) begin
            w_mix_valid_n = 1'b0;
            w_wc_n = r_wc + 32'd1;
            w_burst_n = w_burst_inc;
            w_state_n = !i_enable ? IDLE :
                        (w_burst_inc == 8'(BURST) || !w_sel_en) ? ARB : FETCH;
            w_grant_n = (w_state_n == FETCH) ? r_grant : 2'd3;
          end
        end
        default: w_state_n = IDLE;
      endcase
    end
  end
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_last <= 2'd2;
      r_grant <= 2'd3;
      r_burst <= 8'd0;
      r_ack <= 3'b000;
      r_mix_valid <= 1'b0;
      r_mix_data <= 32'd0;
      r_wc <= 32'd0;
      r_no_source <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_last <= w_last_n;
      r_grant <= w_grant_n;
      r_burst <= w_burst_n;
      r_ack <= w_ack_n;
      r_mix_valid <= w_mix_valid_n;
      r_mix_data <= w_mix_data_n;
      r_wc <= w_wc_n;
      r_no_source <= i_enable && (i_src_enabled == 3'b000);
    end
  end
  assign o_src_ack = r_ack;
  assign o_mix_data = r_mix_data;
  assign o_mix_valid = r_mix_valid;
  assign o_grant = r_grant;
  assign o_no_source = r_no_source;
  assign o_word_count = r_wc;
endmodule

// File: doc/trng_entropy_arbiter.md
# trng_entropy_arbiter

Round-robin scheduler that shares the single entropy-mixer input among three entropy sources (e.g. avalanche, ring-oscillator, and CSPRNG-feedback sources). It grants one enabled source at a time, pulls up to BURST 32-bit words from it over the source's valid/ack handshake, and presents each word to the mixer through a one-entry registered output stage. It sits between the entropy source instances and the mixer in the TRNG core, and honours the core-wide `discard` flush.

## Interface
- BURST, default 4: words taken from a granted source before re-arbitrating; legal range 1–255.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  arbiter enable; low stops new grants.
- discard  in  1  flush; drops any buffered word and forces re-arbitration.
- src_enabled  in  3  per-source enabled flag, bit i = source i.
- src_valid  in  3  per-source word-valid.
- src_data  in  96  source i word on bits [32*i+31 : 32*i].
- src_ack  out  3  per-source one-cycle registered acknowledge.
- mix_data  out  32  word to mixer.
- mix_valid  out  1  mix_data valid; held until mix_ack.
- mix_ack  in  1  mixer accepts word.
- grant  out  2  index of the currently granted source, 0–2. The value 3 means no grant.
- no_source  out  1  registered; high when enable=1 and src_enabled=0.
- word_count  out  32  words delivered to mixer; wraps at 2^32.

## Operation
- The FSM has four states: IDLE, ARB, FETCH, HOLD.
- A round-robin pointer `last` holds the most recently granted index. It is 2 after reset, so the first grant goes to source 0.
- IDLE: when enable=1, go to ARB.
- ARB:
  - If enable=0, go to IDLE.
  - Otherwise search last+1, last+2, last+3 (mod 3) for the first set src_enabled bit.
  - If one is found: set grant and last to that index, clear burst_ctr, go to FETCH.
  - If none is found: stay in ARB with grant=3.
- FETCH:
  - If enable=0, go to IDLE.
  - Else if src_enabled[grant]=0, go to ARB.
  - Else if src_valid[grant]=1: capture src_data[grant] into the output register, drive src_ack[grant] high for exactly the next cycle, set mix_valid, and go to HOLD.
- HOLD:
  - mix_valid=1 and mix_data is stable. Source inputs are ignored.
  - On mix_ack=1: clear mix_valid, increment word_count and burst_ctr.
  - Next state after mix_ack:
    - IDLE if enable=0.
    - ARB if burst_ctr+1 == BURST or src_enabled[grant]=0.
    - FETCH otherwise.
  - If enable drops while in HOLD, the buffered word is still delivered. The exit checks above are applied only on mix_ack.
- discard has the highest priority and applies in any state:
  - Next state ARB (or IDLE if enable=0).
  - mix_valid cleared, mix_data cleared to 0, burst_ctr cleared, grant=3, no src_ack issued.
  - last and word_count are unchanged.
- Arithmetic widths: burst_ctr is 8 bits; word_count is 32 bits, modular.

## Timing
- Reset values:
  - State IDLE, last=2, grant=3.
  - src_ack=0, mix_valid=0, mix_data=0.
  - no_source=0, word_count=0, burst_ctr=0.
- All outputs are registered.
- src_ack is never high for more than one cycle.
- At most one src_ack bit is high at a time.
- Latency from the sampled src_valid edge to mix_valid high: 1 cycle. src_ack pulses in the same cycle that mix_valid rises.
- Minimum cycles per word, with mix_ack held high and src_valid held high: 2 (FETCH, HOLD). A grant change adds 1 ARB cycle.
- mix_ack is ignored when mix_valid=0.
- In any cycle, discard overrides a simultaneous mix_ack: the word is not counted.
- Grant switches only via ARB. There is never a direct FETCH-to-FETCH switch between sources.

## Test plan
- Reset behaviour: all three sources enabled with valid held high, BURST=4, mix_ack held high → grant sequence 0,0,0,0,1,1,1,1,2,…; each src_ack pulse is 1 cycle; word_count=12 after 12 accepted words.
- Disabled source is skipped: src_enabled=3'b101 → grants alternate 0, 2, 0; src_ack[1] is never asserted. With src_enabled=0 and enable=1 → no_source=1, grant=3, mix_valid stays 0.
- Mixer backpressure: mix_ack held low for 10 cycles with src0 data 0xAA55AA55 → mix_valid and mix_data stay stable, no further src_ack; one cycle of mix_ack then drops mix_valid and word_count increments by 1.
- Discard in HOLD with simultaneous mix_ack → next cycle mix_valid=0, mix_data=0, word_count unchanged, state ARB; the next grant is last+1.
- Source disable mid-burst: src_enabled[0] drops during FETCH after word 2 of 4 → re-arbitrate to source 1 without acking source 0 again.
- Async reset asserted mid-HOLD (no clock edge) → mix_valid, src_ack and word_count are 0 immediately; after release, the first grant is source 0.
